// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine: queues fill commands from an Avalon slave and streams one framebuffer word per clock.
// Optional FB_FILL_CHECKER_EN: PATTERN bit31 selects alternating-row checkerboard data.
module fb_fill_engine #(
  parameter int WORDS_PER_ROW = 20,
  parameter int ROWS          = 480,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [14:0] fb_address,
  output logic [31:0] fb_writedata,
  output logic        fb_write
);

`ifdef FB_FILL_CHECKER_EN
  localparam bit CHECKER = 1'b1;
`else
  localparam bit CHECKER = 1'b0;
`endif

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [14:0] WPR   = WORDS_PER_ROW[14:0];
  localparam logic [14:0] NROWS = ROWS[14:0];

  typedef struct packed {
    logic [31:0] pattern;
    logic [4:0]  x0;
    logic [8:0]  y0;
    logic [5:0]  width;
    logic [9:0]  height;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  function automatic logic [31:0] word_data(input logic [31:0] pat, input logic odd);
    if (CHECKER && pat[31])
      word_data = odd ? ~{1'b0, pat[30:0]} : {1'b0, pat[30:0]};
    else
      word_data = pat;
  endfunction

  logic [31:0] pat_q;
  logic [4:0]  x0_q;
  logic [8:0]  y0_q;
  logic [5:0]  width_q;
  logic [9:0]  height_q;
  logic        ovf_q, drop_q;

  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [14:0] w_q, w_d, h_q, h_d, row_base_q, row_base_d;
  logic [14:0] col_q, col_d, row_q, row_d;
  logic [14:0] fb_address_q, fb_address_d;
  logic [31:0] fb_writedata_q, fb_writedata_d;
  logic        fb_write_q, fb_write_d;

  logic reg_wr, go, clr, push_ok, pop, drop_set, fifo_empty, fifo_full, busy;
  logic last_col, last_row;
  logic [14:0] ld_x0, ld_y0, ld_we, ld_he, ld_wmax, ld_hmax, ld_w, ld_h, ld_base;
  logic        ld_drop;
  logic [3:0]  cnt4;

  assign reg_wr     = chipselect & write;
  assign go         = reg_wr && (address == 3'd5);
  assign clr        = reg_wr && (address == 3'd7);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign push_ok    = go && (!fifo_full || pop);
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign last_col   = (col_q == w_q - 15'd1);
  assign last_row   = (row_q == h_q - 15'd1);

  // Clip the latched command against the visible area.
  always_comb begin
    ld_x0   = {10'd0, cmd_q.x0};
    ld_y0   = {6'd0, cmd_q.y0};
    ld_we   = {9'd0, cmd_q.width};
    ld_he   = {5'd0, cmd_q.height};
    ld_drop = (ld_x0 >= WPR) || (ld_y0 >= NROWS) || (ld_we == '0) || (ld_he == '0);
    ld_wmax = WPR - ld_x0;
    ld_hmax = NROWS - ld_y0;
    ld_w    = (ld_we < ld_wmax) ? ld_we : ld_wmax;
    ld_h    = (ld_he < ld_hmax) ? ld_he : ld_hmax;
    ld_base = ld_y0 * WPR + ld_x0;
  end

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    w_d            = w_q;
    h_d            = h_q;
    row_base_d     = row_base_q;
    col_d          = col_q;
    row_d          = row_q;
    pop            = 1'b0;
    drop_set       = 1'b0;
    fb_write_d     = 1'b0;
    fb_address_d   = fb_address_q;
    fb_writedata_d = fb_writedata_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = mem_q[rptr_q];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_drop) begin
          drop_set = 1'b1;
          state_d  = S_IDLE;
        end else begin
          w_d            = ld_w;
          h_d            = ld_h;
          row_base_d     = ld_base;
          col_d          = '0;
          row_d          = '0;
          fb_write_d     = 1'b1;
          fb_address_d   = ld_base;
          fb_writedata_d = word_data(cmd_q.pattern, 1'b0);
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        // The word on the outputs now is (row_q, col_q); prepare the next one.
        if (last_col && last_row) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            cmd_d   = mem_q[rptr_q];
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (last_col) begin
          col_d          = '0;
          row_d          = row_q + 15'd1;
          row_base_d     = row_base_q + WPR;
          fb_write_d     = 1'b1;
          fb_address_d   = row_base_q + WPR;
          fb_writedata_d = word_data(cmd_q.pattern, ~row_q[0]);
        end else begin
          col_d          = col_q + 15'd1;
          fb_write_d     = 1'b1;
          fb_address_d   = row_base_q + col_q + 15'd1;
          fb_writedata_d = word_data(cmd_q.pattern, row_q[0]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wptr_q] <= '{pattern: pat_q, x0: x0_q, y0: y0_q, width: width_q, height: height_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q          <= '0;
      x0_q           <= '0;
      y0_q           <= '0;
      width_q        <= '0;
      height_q       <= '0;
      ovf_q          <= 1'b0;
      drop_q         <= 1'b0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      cnt_q          <= '0;
      state_q        <= S_IDLE;
      cmd_q          <= '0;
      w_q            <= '0;
      h_q            <= '0;
      row_base_q     <= '0;
      col_q          <= '0;
      row_q          <= '0;
      fb_write_q     <= 1'b0;
      fb_address_q   <= '0;
      fb_writedata_q <= '0;
    end else begin
      if (reg_wr) begin
        case (address)
          3'd0: pat_q    <= writedata;
          3'd1: x0_q     <= writedata[4:0];
          3'd2: y0_q     <= writedata[8:0];
          3'd3: width_q  <= writedata[5:0];
          3'd4: height_q <= writedata[9:0];
          default: ;
        endcase
      end
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (clr) begin
        ovf_q  <= 1'b0;
        drop_q <= 1'b0;
      end
      if (go && !push_ok) ovf_q  <= 1'b1;
      if (drop_set)       drop_q <= 1'b1;
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      w_q            <= w_d;
      h_q            <= h_d;
      row_base_q     <= row_base_d;
      col_q          <= col_d;
      row_q          <= row_d;
      fb_write_q     <= fb_write_d;
      fb_address_q   <= fb_address_d;
      fb_writedata_q <= fb_writedata_d;
    end
  end

  always_comb begin
    cnt4 = '0;
    cnt4[CNT_W-1:0] = cnt_q;
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        3'd0: readdata = pat_q;
        3'd1: readdata = {27'd0, x0_q};
        3'd2: readdata = {23'd0, y0_q};
        3'd3: readdata = {26'd0, width_q};
        3'd4: readdata = {22'd0, height_q};
        3'd6: readdata = {24'd0, cnt4, 1'b0, drop_q, ovf_q, busy};
        default: readdata = '0;
      endcase
    end
  end

  assign fb_write     = fb_write_q;
  assign fb_address   = fb_address_q;
  assign fb_writedata = fb_writedata_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Bench for fb_fill_engine: a command-level schedule model predicts every framebuffer write cycle.
module tb_fb_fill_engine;
  localparam int WPR = 20;
  localparam int NR = 480;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, chipselect, write, read;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [14:0] fb_address;
  logic [31:0] fb_writedata;
  logic        fb_write;

  fb_fill_engine #(.WORDS_PER_ROW(WPR), .ROWS(NR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .fb_address(fb_address), .fb_writedata(fb_writedata), .fb_write(fb_write)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Model: expected write per clock edge index, keyed by the edge that launches it.
  logic [46:0] exp_wr [int];
  int pop_edges[$];
  int m_last_e = -10;
  int m_pat, m_x0, m_y0, m_w, m_h;
  bit m_ovf, m_drop;
  bit chk_en = 1'b0;

  typedef struct { int c; logic [14:0] a; logic [31:0] d; } obs_t;
  obs_t log_q[$];

  function automatic logic [31:0] model_data(input logic [31:0] p, input int row);
`ifdef FB_FILL_CHECKER_EN
    if (p[31]) return (row % 2 == 1) ? ~{1'b0, p[30:0]} : {1'b0, p[30:0]};
`endif
    return p;
  endfunction

  task automatic model_go(input int n);
    int cnt, l, w, h;
    bit popn;
    cnt = 0;
    popn = 1'b0;
    foreach (pop_edges[i]) begin
      if (pop_edges[i] >= n) cnt++;
      if (pop_edges[i] == n) popn = 1'b1;
    end
    if (cnt >= DEPTH && !popn) begin
      m_ovf = 1'b1;
      return;
    end
    l = (n + 2 > m_last_e + 2) ? n + 2 : m_last_e + 2;
    pop_edges.push_back(l - 1);
    if (m_x0 >= WPR || m_y0 >= NR || m_w == 0 || m_h == 0) begin
      m_drop = 1'b1;
      m_last_e = l;
      return;
    end
    w = (m_w < WPR - m_x0) ? m_w : WPR - m_x0;
    h = (m_h < NR - m_y0) ? m_h : NR - m_y0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_wr[l + r * w + c] = {15'((m_y0 + r) * WPR + m_x0 + c), model_data(m_pat, r)};
    m_last_e = l + w * h - 1;
  endtask

  task automatic model_reset(input int r);
    int keys[$];
    foreach (exp_wr[k]) if (k >= r) keys.push_back(k);
    foreach (keys[i]) exp_wr.delete(keys[i]);
    pop_edges.delete();
    m_last_e = -10;
    m_pat = 0; m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0;
    m_ovf = 1'b0; m_drop = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [46:0] e;
      total++;
      if (exp_wr.exists(cyc)) begin
        e = exp_wr[cyc];
        if (fb_write !== 1'b1 || fb_address !== e[46:32] || fb_writedata !== e[31:0]) begin
          bad++;
          $display("FAIL fb_word edge=%0d got w=%b a=%0d d=%h expected w=1 a=%0d d=%h",
                   cyc, fb_write, fb_address, fb_writedata, e[46:32], e[31:0]);
        end
        exp_wr.delete(cyc);
      end else if (fb_write !== 1'b0) begin
        bad++;
        $display("FAIL fb_idle edge=%0d got w=%b a=%0d expected w=0", cyc, fb_write, fb_address);
      end
      if (fb_write === 1'b1) log_q.push_back('{cyc, fb_address, fb_writedata});
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    int n;
    n = cyc + 1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    case (a)
      3'd0: m_pat = int'(d);
      3'd1: m_x0 = int'(d[4:0]);
      3'd2: m_y0 = int'(d[8:0]);
      3'd3: m_w = int'(d[5:0]);
      3'd4: m_h = int'(d[9:0]);
      3'd5: model_go(n);
      3'd7: begin m_ovf = 1'b0; m_drop = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #2;
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    int r;
    r = cyc + 1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset(r);
  endtask

  task automatic wait_done();
    int lim;
    lim = 0;
    while (cyc <= m_last_e + 1 && lim < 12000) begin
      @(posedge clk); #1;
      lim++;
    end
    check("wait_done_timeout", 32'(lim >= 12000), 32'd0);
  endtask

  task automatic wait_edge(input int e);
    int lim;
    lim = 0;
    while (cyc < e && lim < 12000) begin
      @(posedge clk); #1;
      lim++;
    end
    check("wait_edge_timeout", 32'(lim >= 12000), 32'd0);
  endtask

  task automatic setup(input logic [31:0] p, input int x, input int y, input int w, input int h);
    reg_wr(3'd0, p);
    reg_wr(3'd1, 32'(x));
    reg_wr(3'd2, 32'(y));
    reg_wr(3'd3, 32'(w));
    reg_wr(3'd4, 32'(h));
  endtask

  initial begin
    logic [31:0] rd;
    int e, l;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset(0);
    chk_en = 1'b1;

    // Reset state and register readback
    check("rst_fb_write", 32'(fb_write), 32'd0);
    check("rst_fb_address", 32'(fb_address), 32'd0);
    check("rst_fb_writedata", fb_writedata, 32'd0);
    reg_rd(3'd6, rd); check("rst_status", rd, 32'h0);
    reg_rd(3'd0, rd); check("rst_pattern", rd, 32'h0);
    reg_wr(3'd0, 32'hA5A5_1234);
    reg_wr(3'd1, 32'hFFFF_FFFF);
    reg_wr(3'd2, 32'h0000_FFFF);
    reg_rd(3'd0, rd); check("rd_pattern", rd, 32'hA5A5_1234);
    reg_rd(3'd1, rd); check("rd_x0_masked", rd, 32'h1F);
    reg_rd(3'd2, rd); check("rd_y0_masked", rd, 32'h1FF);
    chipselect = 1'b0; read = 1'b1; address = 3'd0; #2;
    check("rd_unselected", readdata, 32'h0);
    read = 1'b0; #1;

    // Full clear
    setup(32'h0, 0, 0, 20, 480);
    log_q.delete();
    reg_wr(3'd5, 32'h0);
    e = m_last_e;
    wait_edge(e);
    reg_rd(3'd6, rd); check("clear_busy_last_write", rd, 32'h1);
    @(posedge clk); #1;
    reg_rd(3'd6, rd); check("clear_busy_after", rd, 32'h0);
    check("clear_count", 32'(log_q.size()), 32'd9600);
    check("clear_first_addr", 32'(log_q[0].a), 32'd0);
    check("clear_last_addr", 32'(log_q[log_q.size()-1].a), 32'd9599);
    check("clear_span", 32'(log_q[log_q.size()-1].c - log_q[0].c), 32'd9599);

    // Clipping at the bottom-right corner
    setup(32'hFFFF_FFFF, 18, 478, 5, 5);
    log_q.delete();
    reg_wr(3'd5, 32'h0);
    wait_done();
    check("clip_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      check("clip_a0", 32'(log_q[0].a), 32'd9578);
      check("clip_a1", 32'(log_q[1].a), 32'd9579);
      check("clip_a2", 32'(log_q[2].a), 32'd9598);
      check("clip_a3", 32'(log_q[3].a), 32'd9599);
      check("clip_d3", log_q[3].d, 32'hFFFF_FFFF);
    end

    // Drop on out-of-range X0
    reg_wr(3'd1, 32'd20);
    log_q.delete();
    reg_wr(3'd5, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("drop_no_writes", 32'(log_q.size()), 32'd0);
    reg_rd(3'd6, rd); check("drop_status", rd, {29'd0, m_drop, m_ovf, 1'b0});
    check("drop_status_lit", rd, 32'h4);
    reg_wr(3'd7, 32'h0);
    reg_rd(3'd6, rd); check("drop_cleared", rd, 32'h0);

    // Overflow: long fill, then five queued commands
    setup(32'h1111_1111, 0, 0, 20, 10);
    log_q.delete();
    reg_wr(3'd5, 32'h0);
    reg_wr(3'd2, 32'd100);
    reg_wr(3'd3, 32'd2);
    reg_wr(3'd4, 32'd1);
    for (int k = 0; k < 5; k++) begin
      reg_wr(3'd0, 32'h100 + 32'(k));
      reg_wr(3'd1, 32'(2 * k));
      reg_wr(3'd5, 32'h0);
    end
    reg_rd(3'd6, rd); check("ovf_status_busy", rd, 32'h43);
    wait_done();
    reg_rd(3'd6, rd); check("ovf_status_idle", rd, 32'h2);
    check("ovf_count", 32'(log_q.size()), 32'd208);
    if (log_q.size() == 208) begin
      for (int k = 0; k < 4; k++) begin
        check("ovf_cmd_addr", 32'(log_q[200 + 2 * k].a), 32'd2000 + 32'(2 * k));
        check("ovf_cmd_data", log_q[201 + 2 * k].d, 32'h100 + 32'(k));
        check("ovf_bubble", 32'(log_q[200 + 2 * k].c - log_q[199 + 2 * k].c), 32'd2);
      end
    end
    reg_wr(3'd7, 32'h0);

    // Reset in the middle of a full clear
    setup(32'h0, 0, 0, 20, 480);
    log_q.delete();
    reg_wr(3'd5, 32'h0);
    l = m_last_e - 9599;
    wait_edge(l + 99);
    do_reset();
    check("rst_mid_fb_write", 32'(fb_write), 32'd0);
    reg_rd(3'd6, rd); check("rst_mid_status", rd, 32'h0);
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_writes", 32'(log_q.size()), 32'd100);

    // Checkerboard pattern (plain data when the option is off)
    setup(32'h8000_0055, 0, 0, 2, 2);
    log_q.delete();
    reg_wr(3'd5, 32'h0);
    wait_done();
    check("chk_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      check("chk_a2", 32'(log_q[2].a), 32'd20);
`ifdef FB_FILL_CHECKER_EN
      check("chk_d0", log_q[0].d, 32'h0000_0055);
      check("chk_d1", log_q[1].d, 32'h0000_0055);
      check("chk_d2", log_q[2].d, 32'hFFFF_FFAA);
      check("chk_d3", log_q[3].d, 32'hFFFF_FFAA);
`else
      check("chk_d0", log_q[0].d, 32'h8000_0055);
      check("chk_d2", log_q[2].d, 32'h8000_0055);
`endif
    end

    repeat (4) @(posedge clk);
    #1;
    check("all_expected_seen", 32'(exp_wr.size()), 32'd0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_fill_engine.md
# fb_fill_engine

Command-driven fill engine sitting directly upstream of the VGA framebuffer display, driving its write port (`writedata`, `write`, `address`). Software queues rectangle-fill commands over a small Avalon slave; the engine expands each command into one full 32-bit framebuffer word write per clock. This offloads screen clears and block fills from the CPU.

## Interface
- `WORDS_PER_ROW`, 20: framebuffer words per display row (1280 half-pixel ticks / 64).
- `ROWS`, 480: display rows.
- `FIFO_DEPTH`, 4: command FIFO entries (power of two).
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: synchronous, active-high; one clock, `clk`.
- `chipselect` in 1: Avalon slave select.
- `write` in 1: Avalon register write strobe.
- `read` in 1: Avalon register read strobe.
- `address` in 3: register index.
- `writedata` in 32: register write data.
- `readdata` out 32: register read data, combinational on `address` (zero-latency read).
- `fb_address` out 15: framebuffer word address, registered.
- `fb_writedata` out 32: framebuffer word data, registered.
- `fb_write` out 1: framebuffer write enable, registered.

## Operation
- Registers:
  - 0 PATTERN[31:0]
  - 1 X0[4:0] (word column)
  - 2 Y0[8:0]
  - 3 WIDTH[5:0] (words)
  - 4 HEIGHT[9:0] (rows)
  - 5 GO: write-only; any write pushes {PATTERN,X0,Y0,WIDTH,HEIGHT} into the FIFO.
  - 6 STATUS, read-only: bit0 busy, bit1 overflow (sticky), bit2 dropped (sticky), bits[7:4] FIFO count.
  - 7 CLEAR: write clears both sticky bits.
- Unused register bits are ignored on write and read as 0. Registers 0–4 reset to 0.
- Parameter registers can be rewritten at any time. Queued commands hold snapshots, so changes only affect later GOs.
- FIFO push/pop rules:
  - Push while full with no pop that cycle: command discarded, overflow set.
  - Push while full with a simultaneous pop: push accepted.
- FSM states:
  - IDLE: if FIFO is non-empty, pop → LOAD.
  - LOAD: clip and latch the command.
    - If X0 ≥ WORDS_PER_ROW, Y0 ≥ ROWS, WIDTH = 0 or HEIGHT = 0: set dropped and return to IDLE; no writes are issued.
    - Otherwise set W = min(WIDTH, WORDS_PER_ROW−X0), H = min(HEIGHT, ROWS−Y0), row_base = Y0·WORDS_PER_ROW + X0 (15 bits), col = 0, row = 0, then go to RUN.
  - RUN: each cycle, drive `fb_write`=1, `fb_address`=row_base+col, `fb_writedata`=pattern.
    - On col = W−1: col←0, row_base += WORDS_PER_ROW, row++.
    - On the last word (col = W−1 and row = H−1): go to LOAD if the FIFO is non-empty (popping it), else IDLE.
- busy = (state ≠ IDLE) or FIFO non-empty.
- Address arithmetic is 15-bit unsigned. Maximum address after clipping is 9599, so no wrap occurs.

## Timing
- Reset values: `fb_write`=0, `fb_address`=0, `fb_writedata`=0, FIFO empty, state IDLE, sticky bits 0.
- `readdata` reads as 0 unless chipselect & read are asserted.
- GO write at edge N, with the engine idle:
  - Pop at edge N+1.
  - LOAD at edge N+2.
  - First `fb_write` high in the cycle after edge N+2.
- Writes within a command are back-to-back with no gaps. A command costs 1 LOAD cycle + W·H write cycles.
- Between queued commands there is exactly one bubble cycle (LOAD), with `fb_write`=0.
- Reset mid-command: `fb_write` is low in the cycle after the reset edge, and the FIFO is flushed.
- Register writes to 0–4 that coincide with GO are not captured by that GO; GO snapshots the pre-edge values.

## Configuration
- `FB_FILL_CHECKER_EN` defined:
  - PATTERN bit31 becomes a mode flag. If set, rows with odd `row` (relative to the command start) write ~{1'b0,PATTERN[30:0]}, and even rows write {1'b0,PATTERN[30:0]}.
  - If bit31 is clear, behaviour is identical to the undefined case.
- Undefined: all 32 PATTERN bits are data, and every word of a command receives PATTERN.

## Test plan
- Full clear: PATTERN=0, X0=0, Y0=0, WIDTH=20, HEIGHT=480, GO → 9600 consecutive writes, addresses 0..9599, data 0; busy drops the cycle after the last write.
- Clipping: X0=18, Y0=478, WIDTH=5, HEIGHT=5, PATTERN=0xFFFFFFFF → exactly 4 writes, at 9578, 9579, 9598, 9599.
- Drop: X0=20 GO → no `fb_write`, STATUS bit2=1. A CLEAR write then reads STATUS=0.
- Overflow: engine busy on a long fill, 5 further GO writes with FIFO_DEPTH=4 → 4 queued, overflow=1. Queued commands then execute in order, each separated by exactly one idle cycle.
- Reset mid-fill: assert reset after 100 writes of a full clear → `fb_write`=0 next cycle, STATUS reads 0, and no further writes occur.
- With `FB_FILL_CHECKER_EN`: PATTERN=0x80000055, 2×2 at origin → data 0x55 at addresses 0 and 1, 0xFFFFFFAA at addresses 20 and 21.
